// File: rtl/eth_txbuf_reader.sv
// eth_txbuf_reader: streams a frame of bytes out of a 256x16 word buffer
// through a valid/ready byte port.
// Optional feature: define ETH_TXBUF_PREFETCH_EN to fetch the next word
// while the current one is being sent, giving one byte per clock with
// out_ready held high. Without it each word goes through FETCH and WAIT.
module eth_txbuf_reader #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  base,
    input  logic [9:0]  len,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        rd_ce,
    output logic [7:0]  rd_addr,
    input  logic [15:0] rd_q,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND0 = 3'd3,
        S_SEND1 = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        rd_ce_q, rd_ce_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [15:0] word_q, word_d;

    logic        hs;
    logic        len_ok;
    logic        do_abort;

`ifdef ETH_TXBUF_PREFETCH_EN
    // hold_q keeps a prefetched word if the consumer stalls past its arrival
    logic [15:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic [15:0] nxt_word;
`endif

    function automatic logic [7:0] first_byte(input logic [15:0] w);
        return (LSB_FIRST != 0) ? w[7:0] : w[15:8];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] w);
        return (LSB_FIRST != 0) ? w[15:8] : w[7:0];
    endfunction

    assign hs       = out_valid_q && out_ready;
    assign len_ok   = (len != 10'd0) && (len <= 10'd512);
    assign do_abort = abort && (state_q != S_IDLE);

`ifdef ETH_TXBUF_PREFETCH_EN
    // rd_q is live only in the cycle after the prefetch read; later use the copy
    assign nxt_word = pend_q ? rd_q : hold_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_ce     = rd_ce_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // State and registered outputs/datapath, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_ce_q     <= 1'b0;
            rd_addr_q   <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            ptr_q       <= 8'd0;
            cnt_q       <= 10'd0;
            word_q      <= 16'd0;
`ifdef ETH_TXBUF_PREFETCH_EN
            hold_q      <= 16'd0;
            pend_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_ce_q     <= rd_ce_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
`ifdef ETH_TXBUF_PREFETCH_EN
            hold_q      <= hold_d;
            pend_q      <= pend_d;
`endif
        end
    end

    // Next-state decode; abort from any busy state returns to IDLE
    always_comb begin
        state_d = state_q;
        if (do_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start && !abort && len_ok) state_d = S_FETCH;
                S_FETCH: state_d = S_WAIT;
                S_WAIT:  state_d = S_SEND0;
                S_SEND0: if (hs) state_d = (cnt_q == 10'd1) ? S_IDLE : S_SEND1;
                S_SEND1: begin
                    if (hs) begin
`ifdef ETH_TXBUF_PREFETCH_EN
                        state_d = (cnt_q == 10'd1) ? S_IDLE : S_SEND0;
`else
                        state_d = (cnt_q == 10'd1) ? S_IDLE : S_FETCH;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next values of registered outputs, word pointer, byte counter and word
    always_comb begin
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rd_ce_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
`ifdef ETH_TXBUF_PREFETCH_EN
        pend_d      = rd_ce_q && (state_q != S_FETCH);
        hold_d      = pend_q ? rd_q : hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (len_ok) begin
                        busy_d    = 1'b1;
                        rd_ce_d   = 1'b1;
                        rd_addr_d = base;
                        ptr_d     = base + 8'd1;
                        cnt_d     = len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                word_d      = rd_q;
                out_valid_d = 1'b1;
                out_data_d  = first_byte(rd_q);
                out_last_d  = (cnt_q == 10'd1);
`ifdef ETH_TXBUF_PREFETCH_EN
                if (cnt_q > 10'd2) begin
                    rd_ce_d   = 1'b1;
                    rd_addr_d = ptr_q;
                    ptr_d     = ptr_q + 8'd1;
                end
`endif
            end
            S_SEND0: begin
                if (hs) begin
                    cnt_d = cnt_q - 10'd1;
                    if (cnt_q == 10'd1) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_data_d = second_byte(word_q);
                        out_last_d = (cnt_q == 10'd2);
                    end
                end
            end
            S_SEND1: begin
                if (hs) begin
                    cnt_d = cnt_q - 10'd1;
                    if (cnt_q == 10'd1) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
`ifdef ETH_TXBUF_PREFETCH_EN
                        word_d     = nxt_word;
                        out_data_d = first_byte(nxt_word);
                        out_last_d = (cnt_q == 10'd2);
                        // Another word follows only if more than two bytes remain after this one
                        if (cnt_q > 10'd3) begin
                            rd_ce_d   = 1'b1;
                            rd_addr_d = ptr_q;
                            ptr_d     = ptr_q + 8'd1;
                        end
`else
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rd_ce_d     = 1'b1;
                        rd_addr_d   = ptr_q;
                        ptr_d       = ptr_q + 8'd1;
`endif
                    end
                end
            end
            default: ;
        endcase
        // Abort drops the frame outright: no done, in-flight read data ignored
        if (do_abort) begin
            busy_d      = 1'b0;
            done_d      = 1'b0;
            rd_ce_d     = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
`ifdef ETH_TXBUF_PREFETCH_EN
            pend_d      = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_eth_txbuf_reader.sv
// Directed bench for eth_txbuf_reader with a behavioural 256x16 buffer.
module tb_eth_txbuf_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  base;
    logic [9:0]  len;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic        rd_ce;
    logic [7:0]  rd_addr;
    logic [15:0] rd_q;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;

    eth_txbuf_reader dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
        .abort(abort), .busy(busy), .done(done), .err(err),
        .rd_ce(rd_ce), .rd_addr(rd_addr), .rd_q(rd_q),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: registered read, data one clock after rd_ce
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (rd_ce) rd_q <= mem[rd_addr];
    end

    // Event monitor, sampled on the falling edge
    int          hs_cnt = 0, rdce_cnt = 0, done_cnt = 0, err_cnt = 0, vld_cnt = 0, stall_bad = 0;
    logic [7:0]  logb [0:2047];
    logic        logl [0:2047];
    logic [7:0]  loga [0:2047];
    logic        st_pend = 1'b0;
    logic [7:0]  st_data = 8'd0;
    logic        st_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (hs_cnt < 2048) begin
                    logb[hs_cnt] <= out_data;
                    logl[hs_cnt] <= out_last;
                end
                hs_cnt <= hs_cnt + 1;
            end
            if (rd_ce) begin
                if (rdce_cnt < 2048) loga[rdce_cnt] <= rd_addr;
                rdce_cnt <= rdce_cnt + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
            if (err) err_cnt <= err_cnt + 1;
            if (out_valid) vld_cnt <= vld_cnt + 1;
            if (st_pend && (!out_valid || out_data != st_data || out_last != st_last))
                stall_bad <= stall_bad + 1;
        end
        st_pend <= !rst && out_valid && !out_ready && !abort;
        st_data <= out_data;
        st_last <= out_last;
    end

    int passed = 0;
    int total = 0;
    int hs0, rc0, dn0, er0, vc0, sb0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic snap();
        hs0 = hs_cnt; rc0 = rdce_cnt; dn0 = done_cnt; er0 = err_cnt; vc0 = vld_cnt; sb0 = stall_bad;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Returns one cycle after the start cycle
    task automatic start_frame(input logic [7:0] b, input logic [9:0] l);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns in the cycle done is high, or after the budget runs out
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    function automatic logic [31:0] pack4(input int i);
        return {logb[i], logb[i+1], logb[i+2], logb[i+3]};
    endfunction

    initial begin
        logic [3:0]  pat;
        logic [15:0] w;
        logic [7:0]  eb;
        int          bad, first, last, nvld, exp_span;

        rst = 1'b1; start = 1'b0; base = 8'd0; len = 10'd0; abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i ^ 8'h5A), 8'(i)};
        mem[8'h10] = 16'hBBAA; mem[8'h11] = 16'hDDCC;
        mem[8'hFF] = 16'h2211; mem[8'h00] = 16'h4433;
        mem[8'h20] = 16'h0201; mem[8'h21] = 16'h0403; mem[8'h22] = 16'h0605;
        mem[8'h40] = 16'h5A6B;

        // Reset state
        step(3);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_rdce", rd_ce, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_pulses", {done, err, out_last}, 0);
        rst = 1'b0;
        step(1);
        check("post_rst_pulses", {done, err, busy}, 0);

        // Basic frame: 0x10/0x11, 4 bytes, first byte three cycles after start
        out_ready = 1'b1;
        snap();
        start_frame(8'h10, 10'd4);
        check("t1_busy", busy, 1);
        check("t1_fetch", {rd_ce, rd_addr}, {1'b1, 8'h10});
        step(1);
        check("t1_nvalid_c2", out_valid, 0);
        step(1);
        check("t1_first", {out_valid, out_data}, {1'b1, 8'hAA});
        wait_done(40);
        check("t1_done_state", {done, busy, out_valid}, 3'b100);
        step(2);
        check("t1_bytes", pack4(hs0), 32'hAABBCCDD);
        check("t1_last", {logl[hs0], logl[hs0+1], logl[hs0+2], logl[hs0+3]}, 4'b0001);
        check("t1_rdce", rdce_cnt - rc0, 2);
        check("t1_addrs", {loga[rc0], loga[rc0+1]}, 16'h1011);
        check("t1_done_cnt", done_cnt - dn0, 1);

        // Pointer wrap 0xFF -> 0x00, odd length
        snap();
        start_frame(8'hFF, 10'd3);
        wait_done(40);
        step(2);
        check("t2_hs", hs_cnt - hs0, 3);
        check("t2_bytes", {logb[hs0], logb[hs0+1], logb[hs0+2]}, 24'h112233);
        check("t2_last", {logl[hs0], logl[hs0+1], logl[hs0+2]}, 3'b001);
        check("t2_addrs", {loga[rc0], loga[rc0+1]}, 16'hFF00);
        check("t2_rdce", rdce_cnt - rc0, 2);
        check("t2_done_cnt", done_cnt - dn0, 1);

        // Illegal lengths 0 and 513
        snap();
        start_frame(8'h10, 10'd0);
        check("t3_err0", {err, busy}, 2'b10);
        start_frame(8'h10, 10'd513);
        check("t3_err513", {err, busy}, 2'b10);
        step(4);
        check("t3_err_cnt", err_cnt - er0, 2);
        check("t3_no_rdce", rdce_cnt - rc0, 0);
        check("t3_no_valid", vld_cnt - vc0, 0);

        // Backpressure 1,0,0,1 and an ignored start (len 0) while busy
        snap();
        pat = 4'b1001;
        @(posedge clk); #1;
        start = 1'b1; base = 8'h20; len = 10'd6;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk); #1;
            start = (k == 4);
            len = (k == 4) ? 10'd0 : 10'd6;
            out_ready = pat[(k + 1) % 4];
        end
        start = 1'b0;
        out_ready = 1'b1;
        step(2);
        check("t4_hs", hs_cnt - hs0, 6);
        check("t4_bytes_a", pack4(hs0), 32'h01020304);
        check("t4_bytes_b", {logb[hs0+4], logb[hs0+5]}, 16'h0506);
        check("t4_last", {logl[hs0+3], logl[hs0+4], logl[hs0+5]}, 3'b001);
        check("t4_stall_stable", stall_bad - sb0, 0);
        check("t4_no_err", err_cnt - er0, 0);
        check("t4_done_cnt", done_cnt - dn0, 1);
        check("t4_rdce", rdce_cnt - rc0, 3);

        // Abort after the second byte of a 10-byte frame
        snap();
        start_frame(8'h30, 10'd10);
        for (int k = 0; k < 50 && (hs_cnt - hs0) < 2; k++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1; out_ready = 1'b0;
        step(1);
        abort = 1'b0;
        check("t5_abort_state", {out_valid, busy}, 2'b00);
        step(5);
        check("t5_no_done", done_cnt - dn0, 0);
        check("t5_hs", hs_cnt - hs0, 2);
        check("t5_bytes", {logb[hs0], logb[hs0+1]}, 16'h306A);

        // Start and abort together in IDLE: the start is dropped
        snap();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base = 8'h40; len = 10'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("t5_drop_start", {busy, rd_ce, err}, 3'b000);
        step(2);
        check("t5_drop_rdce", rdce_cnt - rc0, 0);

        // A new frame after the abort transmits normally
        snap();
        out_ready = 1'b1;
        start_frame(8'h40, 10'd2);
        wait_done(40);
        step(2);
        check("t5_new_bytes", {logb[hs0], logb[hs0+1]}, 16'h6B5A);
        check("t5_new_last", {logl[hs0], logl[hs0+1]}, 2'b01);
        check("t5_new_done", done_cnt - dn0, 1);

        // Full 512-byte frame from address 0, ready held high
        snap();
        first = -1; last = -1; nvld = 0;
        start_frame(8'h00, 10'd512);
        for (int k = 0; k < 3000 && !done; k++) begin
            if (out_valid) begin
                if (first < 0) first = k;
                last = k;
                nvld++;
            end
            @(posedge clk); #1;
        end
        step(2);
        check("t6_hs", hs_cnt - hs0, 512);
        check("t6_rdce", rdce_cnt - rc0, 256);
        check("t6_done_cnt", done_cnt - dn0, 1);
        check("t6_valid_cycles", nvld, 512);
        bad = 0;
        for (int j = 0; j < 512; j++) begin
            w = mem[j / 2];
            eb = (j % 2 == 0) ? w[7:0] : w[15:8];
            if (logb[hs0 + j] !== eb || logl[hs0 + j] !== (j == 511)) bad++;
        end
        check("t6_byte_errors", bad, 0);
`ifdef ETH_TXBUF_PREFETCH_EN
        exp_span = 512;
`else
        // four clocks per word, the last word has no FETCH/WAIT after it
        exp_span = 256 * 4 - 2;
`endif
        check("t6_span", last - first + 1, exp_span);

        // Reset in the middle of a frame
        snap();
        start_frame(8'h10, 10'd4);
        step(2);
        rst = 1'b1;
        step(1);
        check("t7_rst_ctrl", {busy, out_valid, rd_ce, out_last, done, err}, 6'd0);
        check("t7_rst_data", {rd_addr, out_data}, 16'd0);
        rst = 1'b0;
        step(1);
        check("t7_post_rst", {done, err, busy, out_valid}, 4'd0);
        step(6);
        check("t7_no_done", done_cnt - dn0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
